// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared opcodes, ALU codes, FSM state encoding and instruction
//             field positions for the 8-register processor control unit.
//  Revision : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    localparam int INSTR_W = 16;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 3;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LDI  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_BEQZ = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_PASS = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_fsm_if
//  Purpose  : Instruction-memory fetch handshake between control unit
//             (master) and instruction memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface ctrl_fsm_if
    import ctrl_pkg::*;
#(
    parameter int PC_W = 8
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_decode
//  Purpose  : Combinational opcode decode into ALU controls and
//             instruction-class flags for the control FSM.
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] op,
    output logic [2:0] alu_op,
    output logic       alu_src_imm,
    output logic       writes_rd,
    output logic       is_jmp,
    output logic       is_beqz,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        writes_rd   = 1'b0;
        is_jmp      = 1'b0;
        is_beqz     = 1'b0;
        is_halt     = 1'b0;
        is_illegal  = 1'b0;
        case (op)
            OP_NOP:  ;
            OP_ADD:  writes_rd = 1'b1;
            OP_SUB:  begin alu_op = ALU_SUB; writes_rd = 1'b1; end
            OP_AND:  begin alu_op = ALU_AND; writes_rd = 1'b1; end
            OP_OR:   begin alu_op = ALU_OR;  writes_rd = 1'b1; end
            OP_XOR:  begin alu_op = ALU_XOR; writes_rd = 1'b1; end
            OP_ADDI: begin alu_src_imm = 1'b1; writes_rd = 1'b1; end
            OP_LDI:  begin alu_op = ALU_PASS; alu_src_imm = 1'b1; writes_rd = 1'b1; end
            OP_JMP:  is_jmp = 1'b1;
            // Branch tests rt itself: ALU passes B through so alu_zero reflects rt
            OP_BEQZ: begin alu_op = ALU_PASS; is_beqz = 1'b1; end
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_fsm
//  Purpose  : Multi-cycle fetch/decode/exec/writeback sequencer of the
//             8-register processor. Define R0_ZERO_EN to hardwire r0 to zero.
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int PC_W = 8
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    ctrl_fsm_if.master      imem,
    input  logic            alu_zero,
    output logic [2:0]      rs_addr,
    output logic [2:0]      rt_addr,
    output logic [2:0]      alu_op,
    output logic            alu_src_imm,
    output logic [2:0]      reg_waddr,
    output logic            reg_we,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            illegal
);

    state_t               r_state;
    logic [INSTR_W-1:0]   r_ir;
    logic [PC_W-1:0]      r_pc;
    logic                 r_imem_req;
    logic [2:0]           r_alu_op;
    logic                 r_alu_src_imm;
    logic [2:0]           r_reg_waddr;
    logic                 r_reg_we;
    logic                 r_halted;
    logic                 r_illegal;

    logic [2:0]           w_alu_op;
    logic                 w_alu_src_imm;
    logic                 w_writes_rd;
    logic                 w_is_jmp;
    logic                 w_is_beqz;
    logic                 w_is_halt;
    logic                 w_is_illegal;
    logic [2:0]           w_rd;
    logic [PC_W-1:0]      w_imm_pc;
    logic                 w_rd_write;

    ctrl_decode u_decode (
        .op          (r_ir[OP_MSB:OP_LSB]),
        .alu_op      (w_alu_op),
        .alu_src_imm (w_alu_src_imm),
        .writes_rd   (w_writes_rd),
        .is_jmp      (w_is_jmp),
        .is_beqz     (w_is_beqz),
        .is_halt     (w_is_halt),
        .is_illegal  (w_is_illegal)
    );

    assign w_rd     = r_ir[RD_MSB:RD_LSB];
    // Cast zero-extends for wide PCs and truncates when PC_W < 6
    assign w_imm_pc = PC_W'(r_ir[IMM_MSB:IMM_LSB]);

`ifdef R0_ZERO_EN
    assign w_rd_write = (w_rd != 3'd0);
`else
    assign w_rd_write = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ir          <= '0;
            r_pc          <= '0;
            r_imem_req    <= 1'b0;
            r_alu_op      <= ALU_ADD;
            r_alu_src_imm <= 1'b0;
            r_reg_waddr   <= 3'd0;
            r_reg_we      <= 1'b0;
            r_halted      <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem.imem_valid) begin
                        r_ir       <= imem.imem_data;
                        r_pc       <= r_pc + PC_W'(1);
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_alu_op      <= w_alu_op;
                    r_alu_src_imm <= w_alu_src_imm;
                    r_state       <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_writes_rd) begin
                        r_reg_we    <= w_rd_write;
                        r_reg_waddr <= w_rd_write ? w_rd : 3'd0;
                        r_state     <= S_WB;
                    end else if (w_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        if (w_is_jmp || (w_is_beqz && alu_zero))
                            r_pc <= w_imm_pc;
                        if (w_is_illegal)
                            r_illegal <= 1'b1;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_WB: begin
                    r_reg_we   <= 1'b0;
                    r_imem_req <= 1'b1;
                    r_state    <= S_FETCH;
                end
                S_HALT: begin
                    r_imem_req <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_pc;
    // Read addresses come straight from IR, so they are stable DECODE..WB
    assign rs_addr        = r_ir[RS_MSB:RS_LSB];
    assign rt_addr        = r_ir[RT_MSB:RT_LSB];
    assign alu_op         = r_alu_op;
    assign alu_src_imm    = r_alu_src_imm;
    assign reg_waddr      = r_reg_waddr;
    assign reg_we         = r_reg_we;
    assign pc             = r_pc;
    assign halted         = r_halted;
    assign illegal        = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_fsm
//  Purpose  : Self-checking bench for ctrl_fsm with an instruction-memory
//             responder and a writeback scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic       start;
    logic       alu_zero;
    logic [2:0] rs_addr, rt_addr, alu_op, reg_waddr;
    logic       alu_src_imm, reg_we, halted, illegal;
    logic [7:0] pc;

    ctrl_fsm_if #(.PC_W(8)) u_if ();

    ctrl_fsm #(.PC_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem        (u_if),
        .alu_zero    (alu_zero),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_waddr   (reg_waddr),
        .reg_we      (reg_we),
        .pc          (pc),
        .halted      (halted),
        .illegal     (illegal)
    );

    typedef struct {
        logic [2:0] waddr;
        logic [2:0] op;
        logic       imm;
    } wb_exp_t;

    wb_exp_t     sb[$];
    logic [15:0] mem [256];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    int          wait_n  = 0;
    int          wcnt    = 0;
    logic        tie_valid = 1'b0;
    logic        prev_we   = 1'b0;
    logic [2:0]  prev_op   = 3'd0;
    logic        prev_src  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction memory: answers a request after wait_n idle cycles
    always @(negedge clk) begin
        if (tie_valid) begin
            u_if.imem_valid = 1'b1;
            u_if.imem_data  = mem[u_if.imem_addr];
            if (u_if.imem_req) acc_cyc = cyc;
        end else if (u_if.imem_req) begin
            if (wcnt >= wait_n) begin
                u_if.imem_valid = 1'b1;
                u_if.imem_data  = mem[u_if.imem_addr];
                acc_cyc         = cyc;
                wcnt            = 0;
            end else begin
                u_if.imem_valid = 1'b0;
                wcnt++;
            end
        end else begin
            u_if.imem_valid = 1'b0;
            u_if.imem_data  = 16'h0000;
            wcnt            = 0;
        end
    end

    // Writeback monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_we) check("we_one_cycle", reg_we, 0);
            if (reg_we) begin
                check("we_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    wb_exp_t e;
                    e = sb.pop_front();
                    check("wb_waddr", reg_waddr, e.waddr);
                    check("exec_alu_op", prev_op, e.op);
                    check("exec_src_imm", prev_src, e.imm);
                    check("wb_latency", cyc - acc_cyc, 3);
                end
            end
        end
        prev_we  = reg_we;
        prev_op  = alu_op;
        prev_src = alu_src_imm;
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        check("sb_drained", sb.size(), 0);
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_until_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", halted, 1);
    endtask

    task automatic wait_fetch_at(input logic [7:0] a, input int budget, input string tag);
        int   n = 0;
        logic hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            hit = u_if.imem_req && (u_if.imem_addr == a);
        end
        check(tag, hit, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        logic addr_ok;
        rst = 1'b1; start = 1'b0; alu_zero = 1'b0;
        u_if.imem_valid = 1'b0; u_if.imem_data = 16'h0000;
        clear_mem();

        // Reset mid-fetch, then start with valid tied high
        do_reset();
        wait_n = 100;
        pulse_start();
        @(negedge clk);
        check("fetch_req", u_if.imem_req, 1);
        check("fetch_addr0", u_if.imem_addr, 0);
        #2 rst = 1'b1;
        #1 check("rst_outputs", {u_if.imem_req, reg_we, halted, illegal, alu_src_imm,
                                 reg_waddr, rs_addr, rt_addr, alu_op, pc}, 0);
        tie_valid = 1'b1;
        wait_n    = 0;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (u_if.imem_req) cnt++;
        end
        check("idle_ignores_valid", cnt, 0);
        check("idle_pc", pc, 0);
        pulse_start();
        @(negedge clk);
        check("start_req", u_if.imem_req, 1);
        check("start_addr0", u_if.imem_addr, 0);
        tie_valid = 1'b0;
        do_reset();

        // ADD r3,r1,r2 with three wait states, then HALT
        clear_mem();
        mem[0] = 16'h1650; mem[1] = 16'hF000;
        wait_n = 3;
        sb.push_back('{3'd3, 3'd0, 1'b0});
        pulse_start();
        cnt = 0; addr_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!u_if.imem_req) break;
            cnt++;
            if (u_if.imem_addr != 8'd0) addr_ok = 1'b0;
        end
        check("req_hold_cycles", cnt, 4);
        check("req_addr_stable", addr_ok, 1);
        check("decode_rs", rs_addr, 1);
        check("decode_rt", rt_addr, 2);
        check("pc_after_fetch", pc, 1);
        run_until_halt(60);
        check("halt_pc", pc, 2);
        check("halt_req_low", u_if.imem_req, 0);
        pulse_start();
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (u_if.imem_req) cnt++;
        end
        check("halt_ignores_start", cnt, 0);
        check("halt_held", halted, 1);
        do_reset();

        // LDI r7,#42 zero-wait
        clear_mem();
        mem[0] = 16'h7E2A; mem[1] = 16'hF000;
        wait_n = 0;
        sb.push_back('{3'd7, 3'd5, 1'b1});
        pulse_start();
        run_until_halt(30);
        do_reset();

        // SUB/AND/OR/XOR/ADDI program with one wait state per fetch
        clear_mem();
        mem[0] = 16'h2200; mem[1] = 16'h3400; mem[2] = 16'h4800;
        mem[3] = 16'h5A00; mem[4] = 16'h6C09; mem[5] = 16'hF000;
        wait_n = 1;
        sb.push_back('{3'd1, 3'd1, 1'b0});
        sb.push_back('{3'd2, 3'd2, 1'b0});
        sb.push_back('{3'd4, 3'd3, 1'b0});
        sb.push_back('{3'd5, 3'd4, 1'b0});
        sb.push_back('{3'd6, 3'd0, 1'b1});
        pulse_start();
        run_until_halt(100);
        check("prog_pc", pc, 6);
        do_reset();

        // BEQZ #5 taken and not taken
        clear_mem();
        mem[0] = 16'h9005; mem[1] = 16'hF000; mem[5] = 16'hF000;
        wait_n = 0;
        alu_zero = 1'b1;
        pulse_start();
        run_until_halt(40);
        check("beqz_taken_pc", pc, 6);
        do_reset();
        alu_zero = 1'b0;
        pulse_start();
        run_until_halt(40);
        check("beqz_not_taken_pc", pc, 2);
        do_reset();

        // JMP #63 then NOPs up to 255, wrapping to 0
        clear_mem();
        mem[0] = 16'h803F;
        pulse_start();
        wait_fetch_at(8'd63, 30, "jmp_to_63");
        wait_fetch_at(8'd255, 1000, "reach_255");
        wait_fetch_at(8'd0, 20, "wrap_fetch_0");
        check("wrap_pc", pc, 0);
        do_reset();

        // Undefined opcode sets sticky illegal, no write
        clear_mem();
        mem[0] = 16'hA000; mem[1] = 16'hF000;
        pulse_start();
        run_until_halt(40);
        check("illegal_set", illegal, 1);
        check("illegal_pc", pc, 2);
        do_reset();
        check("illegal_cleared", illegal, 0);

        // ADDI r0
        clear_mem();
        mem[0] = 16'h6000; mem[1] = 16'hF000;
`ifndef R0_ZERO_EN
        sb.push_back('{3'd0, 3'd0, 1'b1});
`endif
        pulse_start();
        run_until_halt(40);
        do_reset();

        // Reset during WB aborts the write strobe at once
        clear_mem();
        mem[0] = 16'h1650;
        pulse_start();
        cnt = 0;
        while (!reg_we && cnt < 20) begin
            @(posedge clk);
            #1 cnt++;
        end
        check("we_before_abort", reg_we, 1);
        rst = 1'b1;
        #1 check("abort_we", reg_we, 0);
        check("abort_req", u_if.imem_req, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
